// File: rtl/input_periph.sv
// rtl/input_periph.sv - switch/button synchronizer, debouncer and press-flag register block
// Optional per-button press counters are enabled by defining INPUT_PERIPH_CNT_EN.
module input_periph #(
  parameter int NUM_SW    = 18,
  parameter int NUM_BTN   = 4,
  parameter int DB_CYCLES = 500000,
  parameter int DB_CNT_W  = 20
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SW-1:0]  i_sw,
  input  logic [NUM_BTN-1:0] i_btn_n,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  input  logic               i_wren,
  output logic [31:0]        o_rdata,
  output logic               o_sel,
  output logic               o_btn_irq
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic [NUM_SW-1:0]   sw_s1, sw_s2, sw_stable;
  logic [NUM_BTN-1:0]  btn_s1, btn_s2, btn_sync, btn_stable, btn_prev;
  logic [NUM_BTN-1:0]  btn_flag, btn_rise, btn_clr;
  logic [DB_CNT_W-1:0] sw_cnt  [NUM_SW];
  logic [DB_CNT_W-1:0] btn_cnt [NUM_BTN];
  logic [2:0]          word;
  logic                wr_edge;
  logic                unused_bits;

  // Buttons idle high, so their synchronizer flops reset to the released level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '1;
      btn_s2 <= '1;
    end else begin
      sw_s1  <= i_sw;
      sw_s2  <= sw_s1;
      btn_s1 <= i_btn_n;
      btn_s2 <= btn_s1;
    end
  end

  assign btn_sync = ~btn_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_stable <= '0;
      for (int i = 0; i < NUM_SW; i++) sw_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (sw_s2[i] != sw_stable[i]) begin
          if (sw_cnt[i] == DB_LAST) begin
            sw_stable[i] <= sw_s2[i];
            sw_cnt[i]    <= '0;
          end else begin
            sw_cnt[i] <= sw_cnt[i] + 1'b1;
          end
        end else begin
          sw_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_stable <= '0;
      for (int i = 0; i < NUM_BTN; i++) btn_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_sync[i] != btn_stable[i]) begin
          if (btn_cnt[i] == DB_LAST) begin
            btn_stable[i] <= btn_sync[i];
            btn_cnt[i]    <= '0;
          end else begin
            btn_cnt[i] <= btn_cnt[i] + 1'b1;
          end
        end else begin
          btn_cnt[i] <= '0;
        end
      end
    end
  end

  // Word index: {region, offset[3:2]}; region 1 is the button bank.
  assign o_sel   = (i_addr[31:4] == 28'h000_0780) || (i_addr[31:4] == 28'h000_0781);
  assign word    = {i_addr[4], i_addr[3:2]};
  assign wr_edge = i_wren && o_sel && (word == 3'b101);

  assign btn_rise  = btn_stable & ~btn_prev;
  assign btn_clr   = wr_edge ? i_wdata[NUM_BTN-1:0] : '0;
  assign o_btn_irq = |btn_flag;

  // OR-ing the rise after the clear lets a coincident press survive the W1C.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_prev <= '0;
      btn_flag <= '0;
    end else begin
      btn_prev <= btn_stable;
      btn_flag <= (btn_flag & ~btn_clr) | btn_rise;
    end
  end

`ifdef INPUT_PERIPH_CNT_EN
  logic [7:0] press_cnt [NUM_BTN];
  logic       wr_cnt;

  assign wr_cnt = i_wren && o_sel && (word == 3'b110);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_BTN; k++) press_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_BTN; k++) begin
        if (wr_cnt) begin
          press_cnt[k] <= btn_rise[k] ? 8'd1 : 8'd0;
        end else if (btn_rise[k] && (press_cnt[k] != 8'hFF)) begin
          press_cnt[k] <= press_cnt[k] + 8'd1;
        end
      end
    end
  end
`endif

  always_comb begin
    o_rdata = '0;
    if (o_sel) begin
      case (word)
        3'b000:  o_rdata[NUM_SW-1:0]  = sw_stable;
        3'b100:  o_rdata[NUM_BTN-1:0] = btn_stable;
        3'b101:  o_rdata[NUM_BTN-1:0] = btn_flag;
`ifdef INPUT_PERIPH_CNT_EN
        3'b110: begin
          for (int k = 0; k < NUM_BTN; k++) o_rdata[8*k +: 8] = press_cnt[k];
        end
`endif
        default: o_rdata = '0;
      endcase
    end
  end

  assign unused_bits = ^{i_addr[1:0], i_wdata};

endmodule

// File: doc/input_periph.md
Name: input_periph

Overview:
- Memory-mapped input-side peripheral for the LSU. It is the reader counterpart of the LEDR/LEDG/SEG7/LCD output peripherals.
- Synchronizes and debounces board switches (SW region, 0x0000_7800) and push-buttons (BTN region, 0x0000_7810).
- Captures button presses into sticky write-1-to-clear flags and returns the register value on LSU loads.
- Sits beside the data memory on the MEM-stage address bus.

Parameters:
- NUM_SW, 18, number of switch inputs (max 32).
- NUM_BTN, 4, number of push-buttons (max 4 with the counter feature, max 32 without it).
- DB_CYCLES, 500000, consecutive cycles a synchronized input must hold a new level before it is accepted (10 ms at 50 MHz). Legal range is 2 or more.
- DB_CNT_W, 20, debounce counter width. Must satisfy 2^DB_CNT_W > DB_CYCLES.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_sw  in  NUM_SW  raw switches, active-high, asynchronous to i_clk
- i_btn_n  in  NUM_BTN  raw buttons, active-low (pressed = 0), asynchronous
- i_addr  in  32  LSU byte address
- i_wdata  in  32  LSU store data
- i_wren  in  1  LSU store strobe, one cycle per store
- o_rdata  out  32  read data for i_addr, combinational from internal registers
- o_sel  out  1  1 when i_addr hits this block's map
- o_btn_irq  out  1  OR of all sticky press flags

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst_n is asynchronous and active-low. All state clears immediately on assertion.
- Reset values:
  - Switch synchronizer flops: 0. Button synchronizer flops: 1 (released).
  - Debounced levels: 0. Debounce counters: 0. Press flags: 0. Press counters: 0.
  - Outputs: o_btn_irq = 0. o_rdata reflects the zeroed registers.
- Synchronizer: 2-flop synchronizer per input. Buttons are inverted after synchronization, so internal 1 = pressed.
- Debounce, independently per input:
  - If synced != stable: counter increments.
  - When counter == DB_CYCLES-1 and the mismatch still holds, stable <= synced and counter <= 0 on that edge.
  - If synced == stable at any cycle: counter <= 0. Any glitch restarts the count.
  - Latency from raw change to stable change: 2 sync cycles + DB_CYCLES cycles.
- Press detect: a stable 0->1 transition on button k sets flag[k] on the following edge. Release (1->0) sets nothing.
- Register map (word-aligned; i_addr[1:0] ignored):
  - 0x0000_7800 SW_VAL, read-only. Bits [NUM_SW-1:0] = debounced switches; upper bits 0.
  - 0x0000_7810 BTN_VAL, read-only. Debounced button levels, 1 = pressed.
  - 0x0000_7814 BTN_EDGE, read / write-1-to-clear. Sticky press flags.
  - 0x0000_7818 BTN_CNT, optional feature only; reads 0 and is still selected when the feature is absent.
  - 0x0000_781C reserved: reads 0, writes ignored.
- o_sel = (i_addr[31:4] == 28'h000_0780) or (i_addr[31:4] == 28'h000_0781).
- Any selected offset not listed above reads 0. Unselected addresses drive o_rdata = 0.
- Writes: only when i_wren and the address is BTN_EDGE (or BTN_CNT with the feature). Writes to SW_VAL/BTN_VAL are ignored.
- Simultaneous W1C clear and new press on the same bit: set wins, flag stays 1. Other bits cleared as written.
- o_btn_irq is combinational from the flags; it deasserts on the edge following a clearing write.
- Reset mid-debounce: counters drop to 0. The input must then hold its level for a full window after reset release.

Optional Feature:
- Macro INPUT_PERIPH_CNT_EN.
- Defined: per-button 8-bit press counters, incremented on the same event that sets the flag.
  - BTN_CNT packs button k into bits [8k+7:8k].
  - Counters saturate at 8'hFF.
  - Any write to BTN_CNT clears all counters. An increment coinciding with the clear leaves that counter at 1.
- Undefined: no counter flops. BTN_CNT reads 0 and writes are ignored.

Test Plan (DB_CYCLES=4, DB_CNT_W=3):
- Reset check: hold i_rst_n=0 with i_btn_n=4'hF, i_sw=0 -> reads at 0x7800, 0x7810, 0x7814 return 0; o_btn_irq=0.
- Clean press: drive i_btn_n[1]=0 and hold.
  - BTN_VAL = 32'h2 exactly 6 cycles later.
  - BTN_EDGE = 32'h2 one cycle after that; o_btn_irq=1.
  - Store 32'h2 to 0x7814 -> BTN_EDGE = 0 and o_btn_irq = 0 next cycle.
- Bounce rejection: toggle i_sw[0] with pulses of 3, 2 and 3 cycles, then hold high.
  - SW_VAL bit0 stays 0 during the pulses.
  - SW_VAL bit0 becomes 1 only 6 cycles after the final rise.
- Set beats clear: new press of button 0 lands on the same cycle as a store of 32'hF to 0x7814 while flag[2] is set -> BTN_EDGE = 32'h1.
- Decode: read 0x781C and 0x7900 -> o_rdata = 0. o_sel is 1 for 0x781C and 0 for 0x7900. A store to 0x7810 leaves BTN_VAL unchanged.
- INPUT_PERIPH_CNT_EN: 300 presses of button 3 -> BTN_CNT = 32'hFF00_0000. Store any value to 0x7818 -> BTN_CNT = 0.
